// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXD/CON registers on the shared load/store bus,
// a small TX FIFO, and a maskable sticky completion interrupt.
module uart_tx_periph #(
    parameter int unsigned BAUD_DIV   = 521,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
    parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_irq
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty, fifo_full;
    logic [7:0]       shift;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             overflow, done, ie;
    logic             txd_wr, con_wr, push, pop, baud_wrap, frame_end, tx_nxt;
    logic             unused_wdata;

    assign txd_wr       = wr && (addr == ADDR_TXD);
    assign con_wr       = wr && (addr == ADDR_CON);
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CNT_FULL);
    assign push         = txd_wr && !fifo_full;
    assign baud_wrap    = (baud_cnt == CNT_LAST);
    assign unused_wdata = ^wdata[31:8];

    assign rdata = (rd && addr == ADDR_CON)
                 ? {26'b0, ie, done, overflow, fifo_full, fifo_empty, state != S_IDLE}
                 : '0;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        frame_end = 1'b0;
        tx_nxt    = tx;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    tx_nxt    = shift[0];
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        tx_nxt = shift[bit_idx + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    frame_end = 1'b1;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        tx_nxt    = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state <= state_nxt;
            tx    <= tx_nxt;
            if (state == S_IDLE || baud_wrap)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (pop)
                shift <= mem[rd_ptr];
            if (state_nxt != S_DATA)
                bit_idx <= '0;
            else if (state == S_DATA && baud_wrap)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting events take priority over software clears landing on the same edge.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            overflow <= 1'b0;
            done     <= 1'b0;
            ie       <= 1'b0;
            tx_irq   <= 1'b0;
        end else begin
            if (con_wr)
                ie <= wdata[5];
            if (frame_end)
                done <= 1'b1;
            else if (con_wr && wdata[4])
                done <= 1'b0;
            if (txd_wr && fifo_full)
                overflow <= 1'b1;
            else if (con_wr && wdata[3])
                overflow <= 1'b0;
            tx_irq <= done & ie;
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: a frame-level model checked every cycle,
// plus directed bus sequences with hand-computed expectations.
module tb_uart_tx_periph;
    localparam int unsigned B = 4;
    localparam int unsigned D = 4;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx, tx_irq;

    int n_chk = 0;
    int n_pass = 0;

    uart_tx_periph #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D),
        .ADDR_TXD   (A_TXD),
        .ADDR_CON   (A_CON)
    ) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .tx_irq  (tx_irq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Model: a frame is a 10-bit word {stop, data, start}; position counts cycles into it.
    logic [7:0] mq[$];
    logic [7:0] m_byte;
    logic [9:0] m_frame;
    int         m_pos;
    int         m_pre;
    bit         m_active, m_done, m_ovf, m_ie, m_irq, m_fin;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_frame  = '1;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_ie     = 1'b0;
            m_irq    = 1'b0;
        end else begin
            m_pre = mq.size();
            m_irq = m_done && m_ie;
            m_fin = 1'b0;
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * B) begin
                    m_fin    = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (!m_active && m_pre > 0) begin
                m_byte   = mq.pop_front();
                m_frame  = {1'b1, m_byte, 1'b0};
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (wr && addr == A_CON) begin
                m_ie = wdata[5];
                if (wdata[4]) m_done = 1'b0;
                if (wdata[3]) m_ovf = 1'b0;
            end
            if (m_fin)
                m_done = 1'b1;
            if (wr && addr == A_TXD) begin
                if (m_pre == D) m_ovf = 1'b1;
                else            mq.push_back(wdata[7:0]);
            end
        end
    end

    function automatic logic exp_tx();
        return m_active ? m_frame[m_pos / B] : 1'b1;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (rd && addr == A_CON)
            return {26'b0, m_ie, m_done, m_ovf, mq.size() == D, mq.size() == 0, m_active};
        return '0;
    endfunction

    always @(negedge CLK) begin
        if (Reset_n) begin
            chk("model_tx", tx, exp_tx());
            chk("model_irq", tx_irq, m_irq);
            chk("model_rdata", rdata, exp_rdata());
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        cyc();
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        rd = 1'b1; addr = a;
        #1;
        chk(name, rdata, exp);
        rd = 1'b0; addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    logic [9:0]  pat_a5;
    int unsigned busy_k;
    int unsigned zeros;
    logic        b;

    initial begin
        #1 Reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #2 Reset_n = 1'b1;
        chk("rst_tx", tx, 1);
        chk("rst_irq", tx_irq, 0);
        rd_chk(A_CON, 32'h02, "rst_con");

        // Test 1: single byte, upper write bits ignored; tx bit order 0,1,0,1,0,0,1,0,1,1
        pat_a5 = 10'b11_0100_1010;
        wr_bus(A_TXD, 32'hFFFF_FFA5);
        chk("t1_tx_before_fall", tx, 1);
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("t1_tx_bit", tx, pat_a5[i / 4]);
        end
        cyc();
        rd_chk(A_CON, 32'h12, "t1_con_done");
        chk("t1_irq_masked", tx_irq, 0);

        // Test 2: enable irq; a done-clear on the completion edge loses to the set
        wr_bus(A_CON, 32'h30);
        wr_bus(A_TXD, 32'h3C);
        repeat (40) cyc();
        rd_chk(A_CON, 32'h23, "t2_con_stop");
        chk("t2_irq_pre", tx_irq, 0);
        wr_bus(A_CON, 32'h30);
        rd_chk(A_CON, 32'h32, "t2_done_set_wins");
        chk("t2_irq_lag", tx_irq, 0);
        cyc();
        chk("t2_irq_on", tx_irq, 1);
        wr_bus(A_CON, 32'h30);
        chk("t2_irq_hold", tx_irq, 1);
        cyc();
        chk("t2_irq_off", tx_irq, 0);

        // Test 3: burst of 6 into a 4-deep FIFO; 5 frames back-to-back
        for (int i = 1; i <= 6; i++)
            wr_bus(A_TXD, i);
        rd_chk(A_CON, 32'h2D, "t3_con_full_ovf");
        busy_k = 0;
        do begin
            cyc();
            busy_k++;
            rd = 1'b1; addr = A_CON;
            #1;
            b = rdata[0];
            rd = 1'b0; addr = '0;
        end while (b && busy_k < 400);
        // first frame started 4 edges before the sampling loop began
        chk("t3_burst_cycles", busy_k + 4, 200);
        rd_chk(A_CON, 32'h3A, "t3_con_after");

        // Test 4: mid-frame status and stray accesses
        wr_bus(A_CON, 32'h18);
        wr_bus(A_TXD, 32'h55);
        repeat (10) cyc();
        rd_chk(A_CON, 32'h03, "t4_busy");
        rd_chk(32'h4000_0010, 32'h0, "t4_other_rd");
        rd_chk(A_TXD, 32'h0, "t4_txd_rd");
        wr_bus(32'h4000_0010, 32'hAB);
        wr_bus(32'h4000_0019, 32'hCD);
        rd_chk(A_CON, 32'h03, "t4_stray_wr");
        repeat (40) cyc();
        rd_chk(A_CON, 32'h12, "t4_con_after");

        // Test 5: asynchronous reset during data bit 3 of 0x96 (bit 3 = 0)
        wr_bus(A_CON, 32'h10);
        wr_bus(A_TXD, 32'h96);
        repeat (17) cyc();
        chk("t5_tx_bit3", tx, 0);
        Reset_n = 1'b0;
        #1;
        chk("t5_async_tx", tx, 1);
        chk("t5_async_irq", tx_irq, 0);
        repeat (2) @(posedge CLK);
        #2 Reset_n = 1'b1;
        rd_chk(A_CON, 32'h02, "t5_con_after_rst");
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (tx == 1'b0) zeros++;
        end
        chk("t5_no_residual", zeros, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
